// File: rtl/spi_pkg.sv
// Shared constants for the SPI peripheral front end.
//   SPI_DATA_W       default bits per transfer (din/dout width)
//   SPI_SYNC_STAGES  default depth of each pin synchronizer (must be >= 2)
//   SPI_CNT_W        bit-counter width for the default transfer size
//   SPI_CPOL/CPHA    SPI mode; fixed at mode 0 (idle-low clock, sample on
//                    rising edge, shift on falling edge). Other modes are
//                    not supported.
package spi_pkg;

    localparam int SPI_DATA_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Width of a counter that walks 0..w-1 (at least one bit).
    function automatic int spi_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int SPI_CNT_W = spi_cnt_w(SPI_DATA_W);

endpackage

// File: rtl/spi_peripheral_if.sv
// Signal bundle between an SPI pin driver / register controller and the
// spi_peripheral front end.
//   sclk, cs_n, mosi  SPI pins into the peripheral (asynchronous to clk)
//   miso              SPI data out of the peripheral
//   new_data, din     completed received byte and its one-cycle strobe
//   dout              controller response, sampled the clk after new_data
//   selected          synchronized, inverted chip select
// Modport slave is the peripheral's view; master is the far side's view.
interface spi_peripheral_if #(
    parameter int DATA_W = spi_pkg::SPI_DATA_W
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              new_data;
    logic              selected;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;

    modport slave (
        input  sclk, cs_n, mosi, dout,
        output miso, new_data, din, selected
    );

    modport master (
        output sclk, cs_n, mosi, dout,
        input  miso, new_data, din, selected
    );
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin plus edge detection.
//   clk, rst  system clock, asynchronous active-low reset
//   in        raw asynchronous pin
//   out_sync  value after SYNC_STAGES flops
//   rise/fall single-cycle edge strobes (last stage vs one history flop)
// All flops reset to IDLE so that coming out of reset never looks like an
// edge when the pin sits at its idle level.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out_sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stage_reg;
    logic [SYNC_STAGES-1:0] stage_next;
    logic                   hist_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_next[gi] = in;
            end else begin : g_chain
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_reg <= {SYNC_STAGES{IDLE}};
            hist_reg  <= IDLE;
        end else begin
            stage_reg <= stage_next;
            hist_reg  <= stage_reg[SYNC_STAGES-1];
        end
    end

    assign out_sync = stage_reg[SYNC_STAGES-1];
    assign rise     = out_sync & ~hist_reg;
    assign fall     = ~out_sync & hist_reg;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target front end feeding a byte-wide register controller.
//   clk  system clock (>= 8x sclk)
//   rst  asynchronous active-low reset
//   bus  spi_peripheral_if.slave: sclk/cs_n/mosi in, miso out,
//        new_data/din out to the controller, dout in from it, selected out.
// Bytes arrive MSB first; each completed byte is presented on din with a
// one-clk new_data strobe. The controller's dout, captured one clk after
// the strobe, is shifted out on miso during the next byte of the frame.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    spi_peripheral_if.slave   bus
);

    localparam int   CNT_W          = spi_cnt_w(DATA_W);
    localparam logic SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, unused_mosi_rise, unused_mosi_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE(SPI_CPOL)) u_sclk_sync (
        .clk(clk), .rst(rst), .in(bus.sclk),
        .out_sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .in(bus.cs_n),
        .out_sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .in(bus.mosi),
        .out_sync(mosi_sync), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    logic unused_sclk_level;
    assign unused_sclk_level = sclk_sync;

    logic sample_edge, shift_edge;
    assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;

    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [DATA_W-1:0]      rx_shift_reg;
    logic [DATA_W-1:0]      tx_shift_reg;
    logic [DATA_W-1:0]      din_reg;
    logic                   new_data_reg;
    logic                   byte_done_reg;
    logic                   tx_load_reg;
    // settle_reg fills with ones as the synchronizers flush their reset
    // values; only then does cs_sync reflect the real pin. armed_reg is set
    // once cs_n has genuinely been seen high, so a frame already in progress
    // when reset releases is ignored until cs_n cycles high then low.
    logic [SYNC_STAGES-1:0] settle_reg;
    logic                   armed_reg;
    logic                   selected;

    assign selected = armed_reg & ~cs_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            tx_shift_reg  <= '0;
            din_reg       <= '0;
            new_data_reg  <= 1'b0;
            byte_done_reg <= 1'b0;
            tx_load_reg   <= 1'b0;
            settle_reg    <= '0;
            armed_reg     <= 1'b0;
        end else begin
            settle_reg <= {settle_reg[SYNC_STAGES-2:0], 1'b1};
            if (settle_reg[SYNC_STAGES-1] && cs_sync) begin
                armed_reg <= 1'b1;
            end

            // Byte hand-off pipeline: byte_done -> new_data/din -> tx load.
            byte_done_reg <= 1'b0;
            new_data_reg  <= byte_done_reg;
            tx_load_reg   <= new_data_reg;
            if (byte_done_reg) begin
                din_reg <= rx_shift_reg;
            end
            if (tx_load_reg) begin
                tx_shift_reg <= bus.dout;
            end

            // Chip-select edges take priority over any clock edge seen in
            // the same cycle, so a bit racing deselection is dropped.
            if (cs_fall && armed_reg) begin
                bit_cnt_reg  <= '0;
                rx_shift_reg <= '0;
                tx_shift_reg <= '0;
            end else if (cs_rise) begin
                bit_cnt_reg <= '0;
            end else if (selected) begin
                if (sample_edge) begin
                    rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], mosi_sync};
                    if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_reg   <= '0;
                        byte_done_reg <= 1'b1;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end else if (shift_edge && bit_cnt_reg != '0) begin
                    // At a byte boundary the freshly loaded MSB must stay on
                    // the line for the next byte's first sample edge.
                    tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    assign bus.miso     = selected ? tx_shift_reg[DATA_W-1] : 1'b0;
    assign bus.new_data = new_data_reg;
    assign bus.din      = din_reg;
    assign bus.selected = selected;

endmodule

// File: tb/tb_spi_peripheral.sv
module tb_spi_peripheral;

    localparam int  S      = 2;
    localparam time PERIOD = 20;
    localparam time HALF   = 500;
    localparam time MAX_LAT = (S + 2) * PERIOD;

    logic clk = 1'b0;
    logic rst;
    always #(PERIOD / 2) clk = ~clk;

    spi_peripheral_if #(.DATA_W(8)) bus ();

    spi_peripheral #(.DATA_W(8), .SYNC_STAGES(S)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int mode      = 0;
    int dbl_cnt   = 0;
    logic nd_prev = 1'b0;
    time  last_rise_time = 0;
    logic [7:0] din_log[$];
    time        lat_log[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_lat(input string tag, input time lat);
        total_cnt++;
        assert (lat > 0 && lat <= MAX_LAT) pass_cnt++;
        else $error("FAIL %s: observed latency %0t expected 1..%0t", tag, lat, MAX_LAT);
    endtask

    // Controller model: registered response on the clk where new_data is high.
    always @(posedge clk) begin
        if (!rst)
            bus.dout = 8'h00;
        else if (bus.new_data)
            bus.dout = (mode == 0) ? ((bus.din == 8'h80) ? 8'h07 : 8'h00) : ~bus.din;
    end

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.new_data) begin
            din_log.push_back(bus.din);
            lat_log.push_back($time - last_rise_time);
            if (nd_prev) dbl_cnt++;
        end
        nd_prev = bus.new_data;
    end

    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = tx[7-i];
            #HALF;
            rx = {rx[6:0], bus.miso};
            bus.sclk = 1'b1;
            last_rise_time = $time;
            #HALF;
            bus.sclk = 1'b0;
        end
    endtask

    task automatic run_frame();
        logic [7:0] rx;
        rx_q.delete();
        bus.cs_n = 1'b0;
        #HALF;
        foreach (tx_q[k]) begin
            xfer_bits(tx_q[k], 8, rx);
            rx_q.push_back(rx);
        end
        #HALF;
        bus.cs_n = 1'b1;
        #(2 * HALF);
    endtask

    initial begin
        logic [7:0] rx;
        rst      = 1'b0;
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;

        // Reset held for 10 clk with pin activity.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.sclk = i[0];
            bus.mosi = ~i[0];
            check("rst_miso", {31'd0, bus.miso}, 32'd0);
            check("rst_new_data", {31'd0, bus.new_data}, 32'd0);
            check("rst_din", {24'd0, bus.din}, 32'h00);
            check("rst_selected", {31'd0, bus.selected}, 32'd0);
        end
        @(negedge clk);
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Read transaction: 0x80 then 0x00, controller answers 0x07.
        mode = 0;
        din_log.delete(); lat_log.delete(); dbl_cnt = 0;
        tx_q = '{8'h80, 8'h00};
        run_frame();
        check("read_pulses", din_log.size(), 2);
        check("read_din0", {24'd0, din_log[0]}, 32'h80);
        check("read_din1", {24'd0, din_log[1]}, 32'h00);
        check("read_miso0", {24'd0, rx_q[0]}, 32'h00);
        check("read_miso1", {24'd0, rx_q[1]}, 32'h07);
        check("read_no_double", dbl_cnt, 0);

        // Write pair back-to-back with latency bound.
        din_log.delete(); lat_log.delete();
        tx_q = '{8'h03, 8'hFF};
        run_frame();
        check("wr_pulses", din_log.size(), 2);
        check("wr_din0", {24'd0, din_log[0]}, 32'h03);
        check("wr_din1", {24'd0, din_log[1]}, 32'hFF);
        check_lat("wr_lat0", lat_log[0]);
        check_lat("wr_lat1", lat_log[1]);
        check("wr_no_double", dbl_cnt, 0);

        // Aborted byte: 5 bits of 0xA5 then deselect.
        din_log.delete();
        bus.cs_n = 1'b0;
        #HALF;
        check("abort_selected", {31'd0, bus.selected}, 32'd1);
        xfer_bits(8'hA5, 5, rx);
        bus.cs_n = 1'b1;
        #(2 * HALF);
        check("abort_deselected", {31'd0, bus.selected}, 32'd0);
        check("abort_miso_idle", {31'd0, bus.miso}, 32'd0);
        check("abort_pulses", din_log.size(), 0);
        check("abort_din_hold", {24'd0, bus.din}, 32'hFF);
        tx_q = '{8'hA5};
        run_frame();
        check("abort_retry_pulses", din_log.size(), 1);
        check("abort_retry_din", {24'd0, din_log[0]}, 32'hA5);
        check("abort_retry_miso", {24'd0, rx_q[0]}, 32'h00);

        // Reset in the middle of a byte.
        din_log.delete();
        bus.cs_n = 1'b0;
        #HALF;
        xfer_bits(8'h5A, 3, rx);
        rst = 1'b0;
        #1;
        check("midrst_new_data", {31'd0, bus.new_data}, 32'd0);
        check("midrst_din", {24'd0, bus.din}, 32'h00);
        check("midrst_selected", {31'd0, bus.selected}, 32'd0);
        #(5 * PERIOD - 1);
        rst = 1'b1;
        xfer_bits(8'hD0, 5, rx);
        #HALF;
        bus.cs_n = 1'b1;
        #(2 * HALF);
        check("midrst_pulses", din_log.size(), 0);
        check("midrst_din_after", {24'd0, bus.din}, 32'h00);
        tx_q = '{8'h5A};
        run_frame();
        check("midrst_next_pulses", din_log.size(), 1);
        check("midrst_next_din", {24'd0, din_log[0]}, 32'h5A);

        // Streaming 4-byte frame, controller echoes ~din.
        mode = 1;
        din_log.delete(); dbl_cnt = 0;
        tx_q = '{8'h81, 8'h82, 8'h83, 8'h84};
        run_frame();
        check("stream_pulses", din_log.size(), 4);
        check("stream_din0", {24'd0, din_log[0]}, 32'h81);
        check("stream_din3", {24'd0, din_log[3]}, 32'h84);
        check("stream_miso0", {24'd0, rx_q[0]}, 32'h00);
        check("stream_miso1", {24'd0, rx_q[1]}, 32'h7E);
        check("stream_miso2", {24'd0, rx_q[2]}, 32'h7D);
        check("stream_miso3", {24'd0, rx_q[3]}, 32'h7C);
        check("stream_no_double", dbl_cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI mode-0 target front end that feeds the register controller's byte-wide MMIO interface.
- Oversamples the external SCLK, CS_N and MOSI pins in the system clock domain and assembles MSB-first bytes.
- For each completed byte, presents it on din with a one-cycle new_data pulse.
- Captures the controller's dout response and shifts it out on MISO during the next byte of the same frame.

Parameters:
- DATA_W, 8, bits per SPI transfer; also the width of din and dout.
- SYNC_STAGES, 2, flip-flop depth of each pin synchronizer (minimum 2).

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-low reset; assertion is asynchronous, release is synchronous to clk.
- sclk  in  1  SPI clock pin, asynchronous to clk, idle low.
- cs_n  in  1  SPI chip select pin, active-low, asynchronous.
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out; 0 while deselected.
- new_data  out  1  one-clk pulse marking a completed received byte.
- din  out  DATA_W  last completed received byte, fed to the controller's din.
- dout  in  DATA_W  controller response, valid the clk after new_data.
- selected  out  1  synchronized, inverted cs_n.

Behaviour:
- Reset (rst=0): new_data=0, din=0, miso=0, selected=0. Bit counter, rx shift register and tx shift register all clear to 0. Edge-detect history is set to the idle state: sclk low, cs_n high.
- Synchronization:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flip-flops.
  - Edge detection compares the last synchronized stage with one additional history flip-flop.
  - mosi has the same pipeline delay as sclk, so the sampled bit aligns with its edge.
- Clock ratio: clk frequency must be at least 8x sclk frequency. Slower clk ratios are out of scope and need no detection.
- CS falling edge (selection): bit_cnt=0, rx_shift=0, tx_shift=0. The first byte of every frame therefore returns 0x00 on miso.
- SCLK rising edge while selected:
  - rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}.
  - bit_cnt increments modulo DATA_W.
- Completed byte: when the rising edge brings bit_cnt from DATA_W-1 to 0, on the next clk edge din <= the assembled byte and new_data=1 for exactly one clk. Total latency from the sclk pin edge is SYNC_STAGES+2 clk.
- Response capture: on the clk edge where new_data is high, the controller produces dout; on the following clk edge tx_shift <= dout. This is fixed at one cycle after the new_data pulse.
- SCLK falling edge while selected:
  - If bit_cnt != 0, tx_shift shifts left and fills with 0.
  - If bit_cnt == 0 (byte boundary or frame start), no shift. This keeps the freshly loaded MSB on the line for the next byte's first rising edge.
- miso = selected ? tx_shift[DATA_W-1] : 0.
- CS rising edge (deselection):
  - A partial byte (bit_cnt != 0) is discarded and no new_data pulse is issued.
  - bit_cnt=0.
  - din holds its last value.
- SCLK edges while deselected are ignored.
- Simultaneous edges: if a cs_n rising edge and an sclk rising edge are detected in the same clk cycle, deselection wins and the bit is dropped.
- Back-to-back bytes with no gap are legal. Each completed byte produces its own pulse, and new_data is never asserted for 2 consecutive clk cycles.
- Reset mid-frame: everything returns to reset values immediately. After release, the first cs_n falling edge starts a new frame. Traffic already in progress is ignored until cs_n goes high and then low again, because the edge history resets to idle.

Decomposition:
- spi_pkg holds:
  - the DATA_W and SYNC_STAGES defaults;
  - a bit-counter width constant, $clog2(DATA_W);
  - the SPI mode constants CPOL=0 and CPHA=0, documented as fixed.
- Sub-module sync_edge(clk, rst, in, out_sync, rise, fall) is parameterized by SYNC_STAGES and instantiated 3 times. The mosi instance uses out_sync only.

Test Plan:
- Reset: hold rst=0 for 10 clk while toggling sclk/mosi -> miso=0, new_data=0, din=0x00, selected=0 throughout.
- Read transaction at clk 50 MHz, sclk 1 MHz, with a controller model returning 0x07 after 0x80:
  - Frame bytes 0x80 then 0x00.
  - din=0x80 with a single new_data pulse, then din=0x00 with a pulse.
  - Bits on miso: 0x00 during byte 1, 0x07 during byte 2.
- Write pair: frame bytes 0x03, 0xFF back-to-back -> exactly two pulses, din=0x03 then 0xFF, each within SYNC_STAGES+2 clk of the 8th sclk rise.
- Aborted byte: 5 bits of 0xA5, then cs_n high -> no new_data and din unchanged. A new frame sending 0xA5 gives din=0xA5 and miso 0x00 in that byte.
- Mid-frame reset: assert rst after bit 3 of a byte, release, finish the byte -> no pulse. The next full frame (cs_n high then low) sending 0x5A gives din=0x5A.
- Streaming: 4-byte frame 0x81, 0x82, 0x83, 0x84 with the model echoing ~din -> miso bytes 0x00, 0x7E, 0x7D, 0x7C.
